barrel_shifter_pipe: RTL and testbench

- Parametrised, pipelined successor to the 8-bit combinational barrel shifter.
- Performs arithmetic, logical and circular left/right shifts on a WIDTH-bit operand.
- Implemented as one registered stage per shift-amount bit, with valid/ready handshakes on input and output.
- Sits between a register-file read port and the writeback path of the datapath; keeps the existing opcode encoding and overflow flag and adds an illegal-opcode flag.

---
 rtl/barrel_shifter_pipe.sv | 93 +++++++++
 tb/tb_barrel_shifter_pipe.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined ASL/LSL/ROL/ASR/LSR/ROR shifter.
// An input capture register feeds one register per shift-amount bit.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] s,
  input  logic [2:0]               opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         y,
  output logic                     overflow,
  output logic                     err
);

  localparam int SW = $clog2(WIDTH);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
    logic [2:0]       op;
    logic [SW-1:0]    s;
    logic             ovf;
    logic             err;
  } stage_t;

  stage_t [SW:0] r_st;
  stage_t        w_in;
  logic          w_adv;

  // Shift by 2^k when s[k] is set; overflow accumulates stage by stage.
  // ASL checks the top m+1 bits so neighbouring windows overlap by one.
  function automatic stage_t f_stage(input stage_t x, input int k);
    stage_t           r;
    logic [WIDTH-1:0] top;
    int               m;
    r   = x;
    m   = 1 << k;
    top = x.d >> (WIDTH - 1 - m);
    if (x.s[k] && !x.err) begin
      case (x.op)
        3'b000: begin
          r.d = x.d << m;
          if (top != '0 && top != ({WIDTH{1'b1}} >> (WIDTH - 1 - m)))
            r.ovf = 1'b1;
        end
        3'b001: begin
          r.d = x.d << m;
          if ((x.d >> (WIDTH - m)) != '0)
            r.ovf = 1'b1;
        end
        3'b010: r.d = (x.d << m) | (x.d >> (WIDTH - m));
        3'b100: r.d = $unsigned($signed(x.d) >>> m);
        3'b101: r.d = x.d >> m;
        3'b110: r.d = (x.d >> m) | (x.d << (WIDTH - m));
        default: r.d = x.d;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    w_in     = '0;
    w_in.v   = in_valid;
    w_in.d   = a;
    w_in.op  = opcode;
    w_in.s   = s;
    w_in.err = (opcode[1:0] == 2'b11);
  end

  assign w_adv    = !r_st[SW].v || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= '0;
    end else if (w_adv) begin
      r_st[0] <= w_in;
      for (int k = 0; k < SW; k++)
        r_st[k+1] <= f_stage(r_st[k], k);
    end
  end

  assign out_valid = r_st[SW].v;
  assign y         = r_st[SW].d;
  assign overflow  = r_st[SW].ovf;
  assign err       = r_st[SW].err;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb_barrel_shifter_pipe: scoreboard bench for the pipelined shifter.
// Drives 8- and 16-bit instances; expected results are queued on accept.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, or8, of8, e8;
  logic [7:0]  a8, y8;
  logic [2:0]  s8, op8;
  logic        iv16, ir16, ov16, or16, of16, e16;
  logic [15:0] a16, y16;
  logic [3:0]  s16;
  logic [2:0]  op16;

  barrel_shifter_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .s(s8), .opcode(op8),
    .out_valid(ov8), .out_ready(or8),
    .y(y8), .overflow(of8), .err(e8)
  );

  barrel_shifter_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .s(s16), .opcode(op16),
    .out_valid(ov16), .out_ready(or16),
    .y(y16), .overflow(of16), .err(e16)
  );

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model8(input logic [7:0] a, input int s,
                                  input logic [2:0] op);
    exp_t       e;
    logic [7:0] v;
    v = a;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.acc = 0;
    case (op)
      3'b000: begin
        v = a << s;
        for (int i = 1; i <= s; i++) if (a[7-i] !== a[7]) e.ovf = 1'b1;
      end
      3'b001: begin
        v = a << s;
        for (int i = 0; i < s; i++) if (a[7-i]) e.ovf = 1'b1;
      end
      3'b010: for (int i = 0; i < s; i++) v = {v[6:0], v[7]};
      3'b100: for (int i = 0; i < s; i++) v = {v[7], v[7:1]};
      3'b101: v = a >> s;
      3'b110: for (int i = 0; i < s; i++) v = {v[0], v[7:1]};
      default: e.err = 1'b1;
    endcase
    e.y = {8'h00, v};
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 0; a8 = 0; s8 = 0; op8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; s16 = 0; op16 = 0; or16 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({ov8, y8, of8, e8} !== 11'd0) begin
      failures++;
      $display("FAIL reset8: got v=%b y=%h o=%b e=%b want 0",
               ov8, y8, of8, e8);
    end
    checks++;
    if ({ov16, y16, of16, e16} !== 19'd0) begin
      failures++;
      $display("FAIL reset16: got v=%b y=%h want 0", ov16, y16);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ir8, ir16} !== 2'b11) begin
      failures++;
      $display("FAIL reset_in_ready: got %b%b want 11", ir8, ir16);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] t_op[6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [2:0] t_s[6]  = '{3'd4, 3'd3, 3'd1, 3'd3, 3'd5, 3'd2};
    logic [7:0] t_y[6]  = '{8'h60, 8'h30, 8'h4D, 8'hF4, 8'h05, 8'hA9};
    logic       t_o[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t e;
    int n = 0;
    int got = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      iv8 = (n < 6);
      if (n < 6) begin a8 = 8'hA6; s8 = t_s[n]; op8 = t_op[n]; end
      or8 = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready: got %b want 1", ir8);
      end
      if (ov8 && or8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: got y=%h want nothing", y8);
        end else begin
          e = q8.pop_front();
          got++;
          if ({y8, of8, e8} !== {e.y[7:0], e.ovf, e.err}
              || cyc - e.acc != 3) begin
            failures++;
            $display("FAIL b2b_result: got y=%h o=%b e=%b lat=%0d want y=%h o=%b e=%b lat=3",
                     y8, of8, e8, cyc - e.acc, e.y[7:0], e.ovf, e.err);
          end
        end
      end
      if (iv8 && ir8) begin
        e.y = {8'h00, t_y[n]}; e.ovf = t_o[n]; e.err = 1'b0;
        e.acc = cyc + 1;
        q8.push_back(e);
        n++;
      end
      @(posedge clk);
    end
    iv8 = 1'b0;
    checks++;
    if (got != 6 || q8.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 6", got);
    end
  endtask

  task automatic test_edges();
    logic [7:0] t_a[5]  = '{8'h1F, 8'h20, 8'hFF, 8'h5A, 8'h5A};
    logic [2:0] t_op[5] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd5};
    logic [2:0] t_s[5]  = '{3'd2, 3'd2, 3'd0, 3'd3, 3'd1};
    logic [7:0] t_y[5]  = '{8'h7C, 8'h80, 8'hFF, 8'h5A, 8'h2D};
    logic       t_o[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       t_e[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    int n = 0;
    int got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(negedge clk);
      iv8 = (n < 5);
      if (n < 5) begin a8 = t_a[n]; s8 = t_s[n]; op8 = t_op[n]; end
      or8 = 1'b1;
      #1;
      if (ov8 && or8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL edge_extra: got y=%h want nothing", y8);
        end else begin
          e = q8.pop_front();
          got++;
          if ({y8, of8, e8} !== {e.y[7:0], e.ovf, e.err}) begin
            failures++;
            $display("FAIL edge_result: got y=%h o=%b e=%b want y=%h o=%b e=%b",
                     y8, of8, e8, e.y[7:0], e.ovf, e.err);
          end
        end
      end
      if (iv8 && ir8) begin
        e.y = {8'h00, t_y[n]}; e.ovf = t_o[n]; e.err = t_e[n];
        e.acc = cyc + 1;
        q8.push_back(e);
        n++;
      end
      @(posedge clk);
    end
    iv8 = 1'b0;
    checks++;
    if (got != 5 || q8.size() != 0) begin
      failures++;
      $display("FAIL edge_count: got %0d want 5", got);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] t_a[5]  = '{8'hC3, 8'h96, 8'h7E, 8'h81, 8'h3C};
    logic [2:0] t_op[5] = '{3'd0, 3'd6, 3'd1, 3'd4, 3'd2};
    logic [2:0] t_s[5]  = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd5};
    exp_t e;
    logic [7:0] hy;
    logic hof, he;
    logic hold = 1'b0;
    logic seen = 1'b0;
    int stall = 0;
    int n = 0;
    int got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      iv8 = (n < 5);
      if (n < 5) begin a8 = t_a[n]; s8 = t_s[n]; op8 = t_op[n]; end
      if (ov8 && !seen) begin seen = 1'b1; stall = 4; end
      or8 = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if (ir8 !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready: got %b want 0", ir8);
        end
      end
      if (hold) begin
        checks++;
        if ({ov8, y8, of8, e8} !== {1'b1, hy, hof, he}) begin
          failures++;
          $display("FAIL bp_hold: got v=%b y=%h o=%b e=%b want v=1 y=%h o=%b e=%b",
                   ov8, y8, of8, e8, hy, hof, he);
        end
      end
      hold = ov8 && !or8;
      hy = y8; hof = of8; he = e8;
      if (ov8 && or8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL bp_extra: got y=%h want nothing", y8);
        end else begin
          e = q8.pop_front();
          got++;
          if ({y8, of8, e8} !== {e.y[7:0], e.ovf, e.err}) begin
            failures++;
            $display("FAIL bp_result: got y=%h o=%b e=%b want y=%h o=%b e=%b",
                     y8, of8, e8, e.y[7:0], e.ovf, e.err);
          end
        end
      end
      if (iv8 && ir8) begin
        q8.push_back(model8(t_a[n], int'(t_s[n]), t_op[n]));
        n++;
      end
      if (stall > 0) stall--;
      @(posedge clk);
    end
    iv8 = 1'b0;
    checks++;
    if (got != 5 || q8.size() != 0 || !seen) begin
      failures++;
      $display("FAIL bp_count: got %0d want 5", got);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int n = 0;
    int got = 0;
    for (int c = 0; c < 300 && got < 40; c++) begin
      @(negedge clk);
      iv8 = (n < 40) && ($urandom_range(0, 3) != 0);
      a8  = 8'($urandom);
      s8  = 3'($urandom);
      op8 = 3'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov8 && or8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra: got y=%h want nothing", y8);
        end else begin
          e = q8.pop_front();
          got++;
          if ({y8, of8, e8} !== {e.y[7:0], e.ovf, e.err}) begin
            failures++;
            $display("FAIL rnd_result: got y=%h o=%b e=%b want y=%h o=%b e=%b",
                     y8, of8, e8, e.y[7:0], e.ovf, e.err);
          end
        end
      end
      if (iv8 && ir8) begin
        q8.push_back(model8(a8, int'(s8), op8));
        n++;
      end
      @(posedge clk);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    checks++;
    if (got != 40 || q8.size() != 0) begin
      failures++;
      $display("FAIL rnd_count: got %0d want 40", got);
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int got = 0;
    @(negedge clk);
    or8 = 1'b0;
    iv8 = 1'b1; a8 = 8'h0F; s8 = 3'd1; op8 = 3'd1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h33; s8 = 3'd2; op8 = 3'd6;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    for (int c = 0; c < 10 && !ov8; c++) @(negedge clk);
    checks++;
    if (ov8 !== 1'b1 || y8 !== 8'h1E) begin
      failures++;
      $display("FAIL rst_setup: got v=%b y=%h want v=1 y=1e", ov8, y8);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ov8, y8, of8, e8} !== 11'd0) begin
      failures++;
      $display("FAIL rst_async: got v=%b y=%h o=%b e=%b want 0",
               ov8, y8, of8, e8);
    end
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    or8 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      iv8 = (c == 0);
      a8 = 8'h01; s8 = 3'd7; op8 = 3'd2;
      #1;
      if (ov8 && or8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL rst_stale: got y=%h want nothing", y8);
        end else begin
          e = q8.pop_front();
          got++;
          if ({y8, of8, e8} !== {e.y[7:0], e.ovf, e.err}) begin
            failures++;
            $display("FAIL rst_result: got y=%h o=%b e=%b want y=%h o=%b e=%b",
                     y8, of8, e8, e.y[7:0], e.ovf, e.err);
          end
        end
      end
      if (iv8 && ir8) begin
        e.y = 16'h0080; e.ovf = 1'b0; e.err = 1'b0; e.acc = cyc + 1;
        q8.push_back(e);
      end
      @(posedge clk);
    end
    iv8 = 1'b0;
    checks++;
    if (got != 1 || q8.size() != 0) begin
      failures++;
      $display("FAIL rst_count: got %0d want 1", got);
    end
  endtask

  task automatic test_width16();
    logic [2:0]  t_op[3] = '{3'd2, 3'd4, 3'd1};
    logic [15:0] t_y[3]  = '{16'hC000, 16'hFFFF, 16'h8000};
    logic        t_o[3]  = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    int n = 0;
    int got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      iv16 = (n < 3);
      if (n < 3) begin a16 = 16'h8001; s16 = 4'd15; op16 = t_op[n]; end
      or16 = 1'b1;
      #1;
      if (ov16 && or16) begin
        checks++;
        if (q16.size() == 0) begin
          failures++;
          $display("FAIL w16_extra: got y=%h want nothing", y16);
        end else begin
          e = q16.pop_front();
          got++;
          if ({y16, of16, e16} !== {e.y, e.ovf, e.err}
              || cyc - e.acc != 4) begin
            failures++;
            $display("FAIL w16_result: got y=%h o=%b e=%b lat=%0d want y=%h o=%b e=%b lat=4",
                     y16, of16, e16, cyc - e.acc, e.y, e.ovf, e.err);
          end
        end
      end
      if (iv16 && ir16) begin
        e.y = t_y[n]; e.ovf = t_o[n]; e.err = 1'b0; e.acc = cyc + 1;
        q16.push_back(e);
        n++;
      end
      @(posedge clk);
    end
    iv16 = 1'b0;
    checks++;
    if (got != 3 || q16.size() != 0) begin
      failures++;
      $display("FAIL w16_count: got %0d want 3", got);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_edges();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
